pe_issue_ctrl: RTL
==================

Name: pe_issue_ctrl

Overview:
Command scheduler directly upstream of the pe arithmetic unit. Buffers incoming operation commands in a small FIFO and issues them to the PE one at a time as a single-cycle enable pulse. Waits for the PE done pulse, captures the 16-bit result and returns it to the requester over a valid/ready response channel. Exactly one operation is in flight at the PE at any time.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, minimum 2
TIMEOUT, 16, max cycles in WAIT before abort; used only when PE_ISSUE_TIMEOUT_EN is defined

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept a command
cmd_a  input  8  operand a
cmd_b  input  8  operand b
cmd_c  input  8  operand c (MAC addend)
cmd_op  input  2  0=ADD 1=SUB 2=MUL 3=MAC
pe_a  output  8  to PE op_a
pe_b  output  8  to PE op_b
pe_c  output  8  to PE op_c
pe_op  output  2  to PE op_i
pe_en  output  1  to PE op_en; single-cycle pulse
pe_result  input  16  from PE result
pe_done  input  1  from PE done
rsp_valid  output  1  response available
rsp_ready  input  1  requester accepts response
rsp_result  output  16  captured PE result
rsp_err  output  1  response aborted by timeout
level  output  $clog2(DEPTH)+1  FIFO occupancy
busy  output  1  FSM not in IDLE or FIFO not empty

Behaviour:
- Reset (async assert, sync release): FIFO empty, level=0, FSM=IDLE; pe_a/b/c=0, pe_op=0, pe_en=0, rsp_valid=0, rsp_result=0, rsp_err=0, busy=0. cmd_ready=1 once rst deasserts.
- Reset mid-operation: in-flight and queued commands discarded; pe_done arriving after reset release ignored (FSM in IDLE).
- FIFO: push when cmd_valid && cmd_ready; cmd_ready = (level != DEPTH), registered-level based, no bypass. Pop only on the IDLE->ISSUE transition. Simultaneous push and pop leaves level unchanged. Pointers wrap modulo DEPTH.
- All outputs to PE and response channel are registered.
- FSM:
  IDLE: if FIFO non-empty -> pop head into pe_a/b/c/pe_op, assert pe_en next cycle -> ISSUE.
  ISSUE: pe_en=1 for exactly this cycle; operands held stable -> WAIT.
  WAIT: pe_en=0; on pe_done=1 capture pe_result into rsp_result, rsp_err=0, rsp_valid=1 -> RESP. Operands remain stable throughout WAIT.
  RESP: hold rsp_valid/rsp_result/rsp_err until rsp_valid && rsp_ready; then rsp_valid=0 -> IDLE. No new issue while in RESP (back-pressure stalls PE issue; FIFO still accepts until full).
- Latency, empty FIFO, rsp_ready=1: cmd accepted cycle 0; ISSUE cycle 2 (pe_en high); PE done cycle 3; rsp_valid cycle 4. Back-to-back throughput: one response per 4 cycles.
- pe_done outside WAIT ignored.
- rsp_result is the PE 16-bit value unmodified (SUB wraps in 16 bits, e.g. 5-7 = 16'hFFFE).
- busy = (state != IDLE) || (level != 0).

Optional Feature:
PE_ISSUE_TIMEOUT_EN
- Defined: counter cleared on entry to WAIT, increments each WAIT cycle; if it reaches TIMEOUT without pe_done -> RESP with rsp_result=16'h0000, rsp_err=1. pe_done in the same cycle as expiry wins (normal response, rsp_err=0). Late pe_done afterwards ignored.
- Undefined: no counter; WAIT holds indefinitely; rsp_err tied 0.

Test Plan:
- Single ADD a=3 b=5, rsp_ready=1 -> one pe_en pulse, pe_op=0; rsp_result=16'h0008, rsp_err=0, rsp_valid on cycle 4 after acceptance.
- Sequence SUB 5,7; MUL 255,255; MAC 10,20,7 pushed back-to-back -> responses in order 16'hFFFE, 16'hFE01, 16'h00CF; exactly three pe_en pulses, each one cycle wide.
- DEPTH=4, rsp_ready=0, push 6 commands -> first issued, FIFO holds 4, cmd_ready=0 at level=4; release rsp_ready -> all 5 accepted commands return in order; level drains to 0, busy drops.
- Push while popping at level=DEPTH-1 -> level unchanged, no command lost or duplicated.
- Assert rst in WAIT with 2 queued -> all outputs at reset values immediately; subsequent pe_done produces no response; new ADD 1,1 after release -> 16'h0002.
- PE_ISSUE_TIMEOUT_EN, TIMEOUT=16, pe_done stuck low -> after 16 WAIT cycles rsp_valid=1, rsp_err=1, rsp_result=0; next command completes normally with rsp_err=0.

Source files
------------

// File: rtl/pe_issue_ctrl_if.sv
// Command, PE and response channels of the pe_issue_ctrl scheduler.
// Ports: cmd_* (requester -> FIFO), pe_* (scheduler <-> PE), rsp_* (scheduler -> requester).
// slave = scheduler side, master = environment side (requester plus PE).
interface pe_issue_ctrl_if;
  // command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [7:0]  cmd_c;
  logic [1:0]  cmd_op;
  // PE channel
  logic [7:0]  pe_a;
  logic [7:0]  pe_b;
  logic [7:0]  pe_c;
  logic [1:0]  pe_op;
  logic        pe_en;
  logic [15:0] pe_result;
  logic        pe_done;
  // response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_c, cmd_op, pe_result, pe_done, rsp_ready,
    output cmd_ready, pe_a, pe_b, pe_c, pe_op, pe_en, rsp_valid, rsp_result, rsp_err
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_c, cmd_op, pe_result, pe_done, rsp_ready,
    input  cmd_ready, pe_a, pe_b, pe_c, pe_op, pe_en, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/pe_issue_ctrl.sv
// Purpose: queue PE commands in a DEPTH-entry FIFO and issue them one at a time
//   as a one-cycle pe_en pulse, then return the captured PE result on rsp_*.
// Latency: accept in cycle 0 -> pe_en in cycle 2 -> rsp_valid one cycle after pe_done.
// Backpressure: cmd_ready drops at level==DEPTH; a stalled response blocks further
//   issue while the FIFO keeps accepting until full.
// Ports: clk, rst (async active-high); io (pe_issue_ctrl_if.slave) carrying the
//   cmd/pe/rsp channels; level = FIFO occupancy; busy = FSM active or FIFO non-empty.
// Optional: define PE_ISSUE_TIMEOUT_EN to abort a WAIT lasting TIMEOUT cycles with
//   rsp_err=1 and rsp_result=0; otherwise WAIT is unbounded and rsp_err is tied 0.
module pe_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pe_issue_ctrl_if.slave       io,
  output logic [$clog2(DEPTH):0] level,
  output logic                 busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("pe_issue_ctrl: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] c;
    logic [7:0] b;
    logic [7:0] a;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  cmd_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  state_t          state_q;
  logic [7:0]      pe_a_q, pe_b_q, pe_c_q;
  logic [1:0]      pe_op_q;
  logic            pe_en_q;
  logic            rsp_valid_q;
  logic [15:0]     rsp_result_q;
  logic            cmd_ready;
  logic            push, pop;
  cmd_t            cmd_in, head;

`ifdef PE_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   tmo_cnt_q;
  logic            rsp_err_q;
`endif

  // Ready is derived from the registered level only; a pop in the same cycle
  // does not open a slot for a push (no bypass).
  assign cmd_ready = (level_q != LW'(DEPTH));
  assign push      = io.cmd_valid && cmd_ready;
  // The FIFO is only popped on the IDLE -> ISSUE transition.
  assign pop       = (state_q == IDLE) && (level_q != '0);

  assign cmd_in = '{op: io.cmd_op, c: io.cmd_c, b: io.cmd_b, a: io.cmd_a};
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage needs no reset: entries are only read below the valid level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH falls out of the overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pe_a_q       <= '0;
      pe_b_q       <= '0;
      pe_c_q       <= '0;
      pe_op_q      <= '0;
      pe_en_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
`ifdef PE_ISSUE_TIMEOUT_EN
      rsp_err_q    <= 1'b0;
      tmo_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            pe_a_q  <= head.a;
            pe_b_q  <= head.b;
            pe_c_q  <= head.c;
            pe_op_q <= head.op;
            pe_en_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          pe_en_q <= 1'b0;
          state_q <= WAIT;
`ifdef PE_ISSUE_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        WAIT: begin
          // A done arriving on the expiry cycle still yields a normal response.
          if (io.pe_done) begin
            rsp_result_q <= io.pe_result;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
`ifdef PE_ISSUE_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
          end else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th WAIT cycle without a done.
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            tmo_cnt_q    <= tmo_cnt_q + 1'b1;
`endif
          end
        end
        RESP: begin
          if (rsp_valid_q && io.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.cmd_ready  = cmd_ready;
  assign io.pe_a       = pe_a_q;
  assign io.pe_b       = pe_b_q;
  assign io.pe_c       = pe_c_q;
  assign io.pe_op      = pe_op_q;
  assign io.pe_en      = pe_en_q;
  assign io.rsp_valid  = rsp_valid_q;
  assign io.rsp_result = rsp_result_q;
`ifdef PE_ISSUE_TIMEOUT_EN
  assign io.rsp_err    = rsp_err_q;
`else
  assign io.rsp_err    = 1'b0;
`endif

  assign level = level_q;
  assign busy  = (state_q != IDLE) || (level_q != '0);
endmodule
